// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// Bubbles load-use and jr hazards, squashes taken branches, freezes on dmem waits.
module hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_rs,
    input  logic [4:0]       i_rt,
    input  logic [1:0]       i_jump,
    input  logic             i_branch_taken,
    input  logic [4:0]       i_rf_wa_ex,
    input  logic             i_regwrite_ex,
    input  logic             i_memread_ex,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ready,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_idex_write,
    output logic             o_exmem_write,
    output logic             o_memwb_write,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_flush_pend;
    logic             w_flush_pend_nxt;
    logic [WC_W-1:0]  r_wcnt;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic w_ldu;
    logic w_jrh;
    logic w_bubble;
    logic w_miss;
    logic w_flush_req;
    logic w_bubble_flush;
    logic w_enter_wait;
    logic w_in_wait;

    assign w_ldu = i_memread_ex && (i_rf_wa_ex != 5'd0)
                && ((i_rf_wa_ex == i_rs) || (i_rf_wa_ex == i_rt));
    assign w_jrh = (i_jump == 2'b10) && i_regwrite_ex
                && (i_rf_wa_ex != 5'd0) && (i_rf_wa_ex == i_rs);
    assign w_bubble     = w_ldu || w_jrh;
    assign w_miss       = i_dmem_req && !i_dmem_ready;
    assign w_flush_req  = r_flush_pend || i_branch_taken;
    assign w_in_wait    = (r_state == S_WAIT);
    assign w_enter_wait = !w_in_wait && (w_state_nxt == S_WAIT);

    // Next state and same-cycle enables/flushes; reset forces free-running outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_flush_pend_nxt = r_flush_pend;
        w_bubble_flush   = 1'b0;
        o_pc_write       = 1'b1;
        o_ifid_write     = 1'b1;
        o_idex_write     = 1'b1;
        o_exmem_write    = 1'b1;
        o_memwb_write    = 1'b1;
        o_ifid_flush     = 1'b0;
        o_idex_flush     = 1'b0;
        if (i_rst_n) begin
            case (r_state)
                S_WAIT: begin
                    o_pc_write    = 1'b0;
                    o_ifid_write  = 1'b0;
                    o_idex_write  = 1'b0;
                    o_exmem_write = 1'b0;
                    o_memwb_write = 1'b0;
                    if (i_branch_taken)
                        w_flush_pend_nxt = 1'b1;
                    if (i_dmem_ready)
                        w_state_nxt = S_RELEASE;
                end
                S_RUN, S_RELEASE: begin
                    if (r_state == S_RUN && w_miss) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        if (w_bubble) begin
                            o_pc_write     = 1'b0;
                            o_ifid_write   = 1'b0;
                            o_idex_flush   = 1'b1;
                            w_bubble_flush = 1'b1;
                        end else begin
                            o_ifid_flush     = w_flush_req;
                            w_flush_pend_nxt = 1'b0;
                        end
                        w_state_nxt = w_miss ? S_WAIT : S_RUN;
                    end
                end
                default: w_state_nxt = S_RUN;
            endcase
        end
    end

    // State, pending flush, wait timer, sticky timeout and saturating counters
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_RUN;
            r_flush_pend  <= 1'b0;
            r_wcnt        <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_bubble_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_pend <= w_flush_pend_nxt;
            if (w_enter_wait)
                r_wcnt <= '0;
            else if (w_in_wait && r_wcnt != WC_MAX)
                r_wcnt <= r_wcnt + WC_W'(1);
            if (w_in_wait && r_wcnt >= WC_LAST)
                r_mem_timeout <= 1'b1;
            if (w_in_wait && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_bubble_flush && r_bubble_cnt != '1)
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign o_mem_timeout = r_mem_timeout;
    assign o_stall_cnt   = r_stall_cnt;
    assign o_bubble_cnt  = r_bubble_cnt;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall/flush controller for the 5-stage MIPS core. It produces stage enables and bubble/flush controls for IF, ID, EX and MEM. The forwarding unit covers data hazards by bypassing; this block covers the hazards it cannot: load-use, jr/jalr operands not yet in MEM, taken-branch squash, and multi-cycle data-memory waits. It sits beside the forwarding unit in ID/EX, and its outputs drive the PC and pipeline registers directly.

## Interface
Parameters:
- TIMEOUT, 64: dmem wait cycles before mem_timeout is raised.
- CNT_W, 16: width of performance counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low, sampled on the rising edge of clk.
- rs, rt  in  5 each  source registers of the instruction in ID.
- Jump  in  2  ID jump type; 2'b10 = jr/jalr.
- branch_taken  in  1  ID-resolved taken branch or jump.
- rf_wa_ex  in  5  destination register in EX.
- RegWrite_ex, MemRead_ex  in  1 each  EX write-enable and load flag.
- dmem_req  in  1  MEM stage is issuing a load/store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write, ifid_write, idex_write, exmem_write, memwb_write  out  1 each  register enables.
- ifid_flush, idex_flush  out  1 each  insert bubble into IF/ID and ID/EX.
- mem_timeout  out  1  sticky; set when a wait reaches TIMEOUT.
- stall_cnt, bubble_cnt  out  CNT_W each  saturating counters of WAIT cycles and bubble cycles.

## Operation
- Combinational hazard terms:
  - ldu = MemRead_ex && rf_wa_ex!=0 && (rf_wa_ex==rs || rf_wa_ex==rt).
  - jrh = Jump==2'b10 && RegWrite_ex && rf_wa_ex!=0 && rf_wa_ex==rs.
  - bubble = ldu || jrh.
- After one bubble, the producer is in MEM and the forwarding unit supplies the value (ALU result or load data). A single bubble therefore always suffices.
- FSM states:
  - RUN:
    - If dmem_req && !dmem_ready, go to WAIT.
    - Else if bubble: pc_write=0, ifid_write=0, idex_flush=1; other enables 1; stay in RUN.
    - Else all enables 1. If branch_taken, ifid_flush=1.
  - WAIT:
    - All five enables 0 and both flushes 0; the pipeline is frozen.
    - branch_taken asserted in any WAIT cycle sets flush_pend.
    - On dmem_ready, go to RELEASE.
  - RELEASE (1 cycle):
    - All enables 1.
    - ifid_flush = flush_pend || branch_taken; then clear flush_pend.
    - Bubble terms are evaluated here as in RUN. Bubble wins over flush: if both apply, drop ifid_flush and keep flush_pend set for the next cycle.
    - Next state is RUN, or WAIT if dmem_req && !dmem_ready.
- Priority in any cycle: WAIT freeze > bubble > branch flush.
- Bubble plus branch_taken in the same RUN cycle: bubble only. The branch re-resolves next cycle.
- Wait counter:
  - Counts cycles spent in WAIT and clears on entry to WAIT.
  - On reaching TIMEOUT, sets mem_timeout. mem_timeout stays set until reset. The FSM keeps waiting.
- stall_cnt increments each WAIT cycle. bubble_cnt increments each cycle idex_flush=1 is driven by a bubble. Both saturate at all-ones and never wrap.

## Timing
- Reset (rst_n=0 at an edge) sets:
  - state=RUN, flush_pend=0, wait counter=0, mem_timeout=0, stall_cnt=0, bubble_cnt=0.
  - While rst_n=0, outputs are all enables 1, flushes 0.
- Reset asserted in WAIT takes effect at that edge. Any pending flush is discarded.
- Enables and flushes are same-cycle functions of state and inputs; latency is 0 cycles.
- State and counter updates are visible one cycle later.
- A dmem access ready in its first cycle (dmem_req && dmem_ready) causes no stall and does not enter WAIT.
- The minimum WAIT episode is 1 WAIT cycle plus 1 RELEASE cycle.

## Test plan
- Load-use: lw $t0 in EX (rf_wa_ex=8, MemRead_ex=1), rs=8 in ID -> exactly 1 cycle with pc_write=0, ifid_write=0, idex_flush=1; bubble_cnt increments from 0 to 1; next cycle all enables 1.
- jr hazard: Jump=2'b10, rs=31, RegWrite_ex=1, rf_wa_ex=31 -> 1 bubble. With rf_wa_ex=0 -> no bubble.
- Memory wait: dmem_req=1, dmem_ready low for 3 cycles -> 3 cycles with all enables 0, then 1 RELEASE cycle; stall_cnt=3; mem_timeout=0.
- Branch during freeze: branch_taken pulsed in the 2nd WAIT cycle -> ifid_flush=1 in RELEASE only; flush_pend cleared afterwards.
- Timeout with TIMEOUT=4: dmem_ready held low for 10 cycles -> mem_timeout rises once the wait counter reaches 4 and stays 1 after release; rst_n=0 clears it next edge.
- Saturation with CNT_W=4: 20 consecutive bubble cycles -> bubble_cnt stops at 15.
